// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and lane helpers for the data memory load/store unit
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // One response pipeline stage; word is already zero for stores and errors.
  typedef struct packed {
    logic        valid;
    logic        err;
    size_e       size;
    logic [1:0]  lane;
    logic        uns;
    logic [31:0] word;
  } rsp_stage_t;

  // Byte enables for an aligned store of the given size at the given lane.
  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = 4'b0011 << {lane[1], 1'b0};
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Pick the addressed byte/half out of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                              input logic [1:0] lane, input logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_rsp_pipe.sv
// rtl/mem_rsp_pipe.sv - response pipeline: acceptance capture plus RD_LAT-1 delay stages, extraction at the output
module mem_rsp_pipe
  import mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        err_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        uns_i,
  input  logic [31:0] word_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  rsp_stage_t in_s;
  rsp_stage_t out_s;
  // stage_q[0] is loaded at the accepting edge; the rest only add latency.
  rsp_stage_t stage_q [RD_LAT];

  // Pack the request side into a stage record.
  always_comb begin
    in_s       = '0;
    in_s.valid = valid_i;
    in_s.err   = err_i;
    in_s.size  = size_e'(size_i);
    in_s.lane  = lane_i;
    in_s.uns   = uns_i;
    in_s.word  = word_i;
  end

  // Shift register of stages; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_s;
      for (int i = 1; i < RD_LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_s = stage_q[RD_LAT-1];

  // Output stage: lane selection and extension, forced quiet while in reset.
  always_comb begin
    rsp_valid_o = out_s.valid & ~rst_i;
    rsp_err_o   = out_s.valid & out_s.err & ~rst_i;
    rsp_rdata_o = '0;
    if (out_s.valid && !rst_i) begin
      rsp_rdata_o = load_extend(out_s.word, out_s.size, out_s.lane, out_s.uns);
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - byte-addressed data memory with load/store front end and clear-after-reset
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          busy
);

  localparam int WORDS = DEPTH / 4;
  localparam int WAW   = AW - 2;

  logic [31:0]    mem_q [WORDS];
  state_e         state_q, state_d;
  logic [WAW-1:0] clr_ptr_q, clr_ptr_d;

  size_e          size_s;
  logic [WAW-1:0] word_idx;
  logic [1:0]     lane;
  logic           misaligned;
  logic           accept;
  logic           wr_en;
  logic           rd_en;
  logic [3:0]     be;
  logic [31:0]    wdata_rep;
  logic [31:0]    rd_word;

  assign size_s   = size_e'(req_size);
  assign word_idx = req_addr[AW-1:2];
  assign lane     = req_addr[1:0];

  assign req_ready = (state_q == ST_IDLE) & ~rst;
  assign busy      = (state_q == ST_CLEAR) & ~rst;
  assign accept    = req_valid & req_ready;
  assign wr_en     = accept & req_we & ~misaligned;
  assign rd_en     = accept & ~req_we & ~misaligned;
  assign be        = byte_en(size_s, lane);
  assign rd_word   = rd_en ? mem_q[word_idx] : 32'h0;

  // Alignment check and store-data replication across lanes.
  always_comb begin
    misaligned = 1'b0;
    wdata_rep  = req_wdata;
    case (size_s)
      SZ_BYTE: wdata_rep = {4{req_wdata[7:0]}};
      SZ_HALF: begin
        misaligned = req_addr[0];
        wdata_rep  = {2{req_wdata[15:0]}};
      end
      SZ_WORD: misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Clear sweep: walk every word once, then hand over to IDLE.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + WAW'(1);
        if (clr_ptr_q == WAW'(WORDS - 1)) begin
          state_d   = ST_IDLE;
          clr_ptr_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and sweep pointer; reset restarts any sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage: sweep writes zeros, otherwise byte-enabled store at the accepting edge.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR && !rst) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  mem_rsp_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rsp_pipe (
    .clk_i       (clk),
    .rst_i       (rst),
    .valid_i     (accept),
    .err_i       (misaligned),
    .size_i      (req_size),
    .lane_i      (lane),
    .uns_i       (req_unsigned),
    .word_i      (rd_word),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard bench driving RD_LAT=1 and RD_LAT=3 instances in lockstep
module tb_data_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        rdy1, v1, er1, busy1;
  logic [31:0] rd1;
  logic        rdy3, v3, er3, busy3;
  logic [31:0] rd3;

  data_mem_lsu #(.DEPTH(1024), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(rd1), .rsp_err(er1), .busy(busy1)
  );

  data_mem_lsu #(.DEPTH(1024), .RD_LAT(3), .CLEAR_ON_RESET(1)) u_lat3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v3), .rsp_rdata(rd3), .rsp_err(er3), .busy(busy3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rsp_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;
  logic [7:0] mm [1024];

  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) chk("lat1_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("lat1_rdata", rd1, e1.rdata);
        chk("lat1_err", {31'b0, er1}, {31'b0, e1.err});
        chk("lat1_cycle", cyc, e1.rsp_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (v3) begin
      if (q3.size() == 0) chk("lat3_unexpected_rsp", 32'd1, 32'd0);
      else begin
        e3 = q3.pop_front();
        chk("lat3_rdata", rd3, e3.rdata);
        chk("lat3_err", {31'b0, er3}, {31'b0, e3.err});
        chk("lat3_cycle", cyc, e3.rsp_cyc);
      end
    end
  end

  // Called at posedge+1; leaves at posedge+1 after the accepting edge.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wd);
    int n;
    int a;
    int acc;
    logic err;
    logic [31:0] rd;
    req_valid = 1'b1;
    req_we = we;
    req_size = sz;
    req_unsigned = uns;
    req_addr = addr;
    req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!(rdy1 && rdy3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!(rdy1 && rdy3)) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
    end else begin
      a = int'(addr);
      acc = cyc + 1;
      err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00);
      rd = 32'h0;
      if (!err) begin
        if (we) begin
          mm[a] = wd[7:0];
          if (sz != 2'd0) mm[a+1] = wd[15:8];
          if (sz == 2'd2) begin
            mm[a+2] = wd[23:16];
            mm[a+3] = wd[31:24];
          end
        end else begin
          case (sz)
            2'd0: rd = uns ? {24'h0, mm[a]} : {{24{mm[a][7]}}, mm[a]};
            2'd1: rd = uns ? {16'h0, mm[a+1], mm[a]} : {{16{mm[a+1][7]}}, mm[a+1], mm[a]};
            default: rd = {mm[a+3], mm[a+2], mm[a+1], mm[a]};
          endcase
        end
      end
      q1.push_back('{rdata: rd, err: err, rsp_cyc: 32'(acc)});
      q3.push_back('{rdata: rd, err: err, rsp_cyc: 32'(acc + 2)});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Called right after rst drops (posedge+1); counts cycles spent sweeping.
  task automatic wait_clear();
    int n;
    n = 0;
    while (n < 400) begin
      @(negedge clk);
      if (!(busy1 && busy3 && !rdy1 && !rdy3)) break;
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd256);
    chk("ready_after_clear", {30'b0, rdy1, rdy3}, 32'd3);
    chk("busy_after_clear", {30'b0, busy1, busy3}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", {30'b0, rdy1, rdy3}, 32'd0);
    chk("reset_busy", {30'b0, busy1, busy3}, 32'd0);
    chk("reset_rsp_valid", {30'b0, v1, v3}, 32'd0);
    chk("reset_rsp_err", {30'b0, er1, er3}, 32'd0);
    chk("reset_rdata1", rd1, 32'h0);
    chk("reset_rdata3", rd3, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear();

    // Cleared memory reads as zero, including the top word.
    do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 10'h004, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);

    do_req(1'b1, 2'd2, 1'b0, 10'h000, 32'hABCD_ABCD);
    do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 10'h014, 32'hABCD_FFFF);
    do_req(1'b0, 2'd2, 1'b0, 10'h014, 32'h0);

    do_req(1'b1, 2'd2, 1'b0, 10'h004, 32'hFFFF_0000);
    do_req(1'b1, 2'd0, 1'b0, 10'h005, 32'h0000_0080);
    do_req(1'b0, 2'd2, 1'b0, 10'h004, 32'h0);
    do_req(1'b0, 2'd0, 1'b0, 10'h005, 32'h0);
    do_req(1'b0, 2'd0, 1'b1, 10'h005, 32'h0);

    do_req(1'b1, 2'd1, 1'b0, 10'h016, 32'h0000_8234);
    do_req(1'b0, 2'd1, 1'b0, 10'h016, 32'h0);
    do_req(1'b0, 2'd1, 1'b1, 10'h016, 32'h0);
    do_req(1'b1, 2'd1, 1'b0, 10'h015, 32'h0000_1111);
    do_req(1'b0, 2'd2, 1'b0, 10'h014, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 10'h002, 32'h0);
    do_req(1'b0, 2'd3, 1'b0, 10'h000, 32'h0);
    do_req(1'b1, 2'd3, 1'b0, 10'h000, 32'h1234_5678);
    do_req(1'b0, 2'd2, 1'b0, 10'h000, 32'h0);

    do_req(1'b1, 2'd2, 1'b0, 10'h0C8, 32'hFFFF_0000);
    do_req(1'b0, 2'd2, 1'b0, 10'h0C8, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hF0F0_F0F0);
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);

    // Mixed traffic in a small window so loads hit earlier stores.
    for (int i = 0; i < 32; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'h100 + 10'($urandom_range(0, 15)), $urandom);
    end
    repeat (6) @(posedge clk);
    #1;

    // Reset with two loads in flight: none of their pending responses may appear.
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 10'h0C8, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cycle_rsp_valid", {30'b0, v1, v3}, 32'd0);
    chk("lat1_pending_at_rst", 32'(q1.size()), 32'd1);
    chk("lat3_pending_at_rst", 32'(q3.size()), 32'd2);
    q1.delete();
    q3.delete();
    for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear();
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 10'h0C8, 32'h0);

    for (int i = 0; i < 20; i++) begin
      if (q1.size() == 0 && q3.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("drain_lat1", 32'(q1.size()), 32'd0);
    chk("drain_lat3", 32'(q3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
